sdp_ram_be: RTL and testbench
=============================

# sdp_ram_be

Parametrised simple dual-port block RAM on one clock: one write port with byte enables and one read port. It adds a selectable read-during-write collision mode, an optional output register, a read-valid flag, and a hardware clear engine that zeroes the array after reset or on request. It is the general-purpose storage primitive for FIFOs, line buffers and register files in the memory library.

## Interface
- WIDTH, 32: data word width in bits; must be a multiple of BYTE_W.
- DEPTH, 256: number of words; any value ≥ 2, power of two not required.
- BYTE_W, 8: bits per byte-enable lane; NBE = WIDTH/BYTE_W.
- ADDR_W, $clog2(DEPTH): address width.
- OUT_REG, 0: 0 = read latency 1; 1 = extra output register, read latency 2.
- RDW_NEW, 0: same-address read and write in one cycle; 0 = old data, 1 = new (merged) data.
- CLEAR_ON_RESET, 1: 1 = run the clear sequence automatically after reset release.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wen_i  in  1  write request.
- be_i  in  NBE  byte enables; lane k covers bits [k*BYTE_W +: BYTE_W].
- waddr_i  in  ADDR_W  write address.
- data_i  in  WIDTH  write data.
- ren_i  in  1  read request.
- raddr_i  in  ADDR_W  read address.
- clear_i  in  1  one-cycle pulse; starts a clear sequence.
- data_o  out  WIDTH  read data, held until the next accepted read.
- rvalid_o  out  1  one-cycle pulse; data_o is valid for the read accepted latency cycles earlier.
- ready_o  out  1  high when user reads and writes are accepted.

## Operation
- Write: with wen_i & ready_o, update only the lanes of word waddr_i whose be_i bit is set. be_i = 0 performs no update.
- Read: with ren_i & ready_o, the read is accepted and data_o/rvalid_o follow after the configured latency.
- Address ≥ DEPTH:
  - Write is dropped.
  - Read returns 0 with rvalid_o still pulsed.
- Collision (read and write accepted in the same cycle with raddr_i == waddr_i):
  - RDW_NEW=0: return the pre-write word.
  - RDW_NEW=1: return the pre-write word with the enabled lanes replaced by data_i.
- Clear FSM states and transitions:
  - IDLE → CLEAR on reset release (if CLEAR_ON_RESET) or on clear_i in IDLE.
  - CLEAR writes 0 to address cnt, cnt = 0..DEPTH-1, one word per cycle.
  - CLEAR → IDLE after address DEPTH-1 is written.
  - clear_i during CLEAR is ignored.
- ready_o = (state == IDLE). In CLEAR, wen_i and ren_i are ignored (no write, no rvalid_o).
- Reads already in flight when CLEAR starts still complete and return pre-clear data.
- Reset values:
  - data_o = 0, rvalid_o = 0, internal pipeline valids = 0, cnt = 0.
  - ready_o = 0 if CLEAR_ON_RESET, else 1.
  - State = CLEAR if CLEAR_ON_RESET, else IDLE.
  - The memory array itself is not reset.
- Reset asserted mid-clear: sequence aborts; on release it restarts from address 0 (if CLEAR_ON_RESET).

## Timing
- Read accepted in cycle T:
  - OUT_REG=0: data_o and rvalid_o in cycle T+1.
  - OUT_REG=1: data_o and rvalid_o in cycle T+2.
- Back-to-back reads every cycle are supported; throughput is 1 word per cycle per port.
- A write in cycle T is visible to a non-colliding read accepted in cycle T+1 or later.
- Clear duration: exactly DEPTH cycles with ready_o low. ready_o rises in the cycle after address DEPTH-1 is written; user access is allowed from that cycle.
- clear_i sampled in IDLE → ready_o low from the next cycle.
- rvalid_o never stays high for more than one cycle per accepted read.

## Structure
- Shared package sdp_ram_pkg:
  - clear FSM state enum (IDLE, CLEAR);
  - function computing NBE;
  - parameter-legality checks (WIDTH % BYTE_W == 0, DEPTH ≥ 2), enforced by elaboration-time assertions.
- Sub-module sdp_ram_clear_fsm (clk, rst_n, clear_i, start-on-reset, cnt, busy, done). It drives the clear address and write strobe, which the top muxes onto the write port ahead of the user port.
- Top keeps the array, byte-lane write loop, collision bypass mux and the OUT_REG generate branch.

## Test plan
- Reset release with DEPTH=16, CLEAR_ON_RESET=1 → ready_o low for exactly 16 cycles; reading all 16 addresses afterwards returns 0.
- Write 0xAABBCCDD to addr 3 with be_i=4'b1111, then 0x11223344 with be_i=4'b0101 → read of addr 3 returns 0xAA22CC44 one cycle after the read is accepted (OUT_REG=0).
- Collision on addr 5 holding 0x0, writing 0xFFFFFFFF with be_i=4'b0011 → RDW_NEW=0 returns 0x00000000; RDW_NEW=1 returns 0x0000FFFF.
- OUT_REG=1, reads on addr 0,1,2 in consecutive cycles → rvalid_o high for 3 consecutive cycles starting 2 cycles after the first read, data in order.
- clear_i pulse after filling memory, with wen_i held high during CLEAR → no writes land; all words read 0 after ready_o rises.
- rst_n asserted at clear address 7 of 16 → outputs go to reset values immediately; after release, the clear restarts and lasts 16 full cycles.

Source files
------------

// File: rtl/sdp_ram_pkg.sv
// sdp_ram_pkg: shared types and parameter helpers for the simple dual-port RAM.
package sdp_ram_pkg;
  typedef enum logic {IDLE, CLEAR} clr_state_e;
  function automatic int nbe(int width, int byte_w);
    return width / byte_w;
  endfunction
  function automatic bit params_ok(int width, int byte_w, int depth);
    return byte_w > 0 && width % byte_w == 0 && depth >= 2;
  endfunction
endpackage

// File: rtl/sdp_ram_clear_fsm.sv
// sdp_ram_clear_fsm: walks every address once, one word per cycle, to zero the array.
module sdp_ram_clear_fsm
  import sdp_ram_pkg::*;
#(
  parameter int DEPTH          = 256,
  parameter int ADDR_W         = $clog2(DEPTH),
  parameter bit START_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  output logic [ADDR_W-1:0] cnt,
  output logic              busy,
  output logic              done
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  clr_state_e state, state_nx;
  logic [ADDR_W-1:0] cnt_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= START_ON_RESET ? CLEAR : IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end
  always_comb begin
    busy     = state == CLEAR;
    done     = busy && cnt == LAST;
    state_nx = busy ? (done ? IDLE : CLEAR) : (clear_i ? CLEAR : IDLE);
    cnt_nx   = busy && !done ? cnt + 1'b1 : '0;
  end
endmodule

// File: rtl/sdp_ram_be.sv
// sdp_ram_be: byte-enable simple dual-port RAM with collision mode, optional output register and clear engine.
module sdp_ram_be
  import sdp_ram_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int DEPTH          = 256,
  parameter int BYTE_W         = 8,
  parameter int ADDR_W         = $clog2(DEPTH),
  parameter bit OUT_REG        = 0,
  parameter bit RDW_NEW        = 0,
  parameter bit CLEAR_ON_RESET = 1,
  localparam int NBE           = nbe(WIDTH, BYTE_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wen_i,
  input  logic [NBE-1:0]    be_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  data_i,
  input  logic              ren_i,
  input  logic [ADDR_W-1:0] raddr_i,
  input  logic              clear_i,
  output logic [WIDTH-1:0]  data_o,
  output logic              rvalid_o,
  output logic              ready_o
);
  if (!params_ok(WIDTH, BYTE_W, DEPTH)) begin : g_bad_params
    $error("sdp_ram_be: WIDTH must be a multiple of BYTE_W and DEPTH must be >= 2");
  end
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] clr_addr;
  logic busy, clr_done_unused;
  logic acc_w, acc_r, in_r, hit;
  logic [WIDTH-1:0] old_w, new_w, rd_w;
  sdp_ram_clear_fsm #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .START_ON_RESET(CLEAR_ON_RESET)) u_clr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (clear_i),
    .cnt     (clr_addr),
    .busy    (busy),
    .done    (clr_done_unused)
  );
  assign ready_o = ~busy;
  always_comb begin
    acc_w = wen_i && ready_o && {1'b0, waddr_i} < DEPTH_A;
    acc_r = ren_i && ready_o;
    in_r  = {1'b0, raddr_i} < DEPTH_A;
    old_w = in_r ? mem[raddr_i] : '0;
    new_w = old_w;
    for (int k = 0; k < NBE; k++)
      new_w[k*BYTE_W +: BYTE_W] = be_i[k] ? data_i[k*BYTE_W +: BYTE_W] : old_w[k*BYTE_W +: BYTE_W];
    hit  = RDW_NEW && acc_w && waddr_i == raddr_i;
    rd_w = hit ? new_w : old_w;
  end
  // Clear engine owns the write port while busy; user writes are dropped then.
  always_ff @(posedge clk) begin
    if (busy)
      mem[clr_addr] <= '0;
    else if (acc_w)
      for (int k = 0; k < NBE; k++)
        if (be_i[k]) mem[waddr_i][k*BYTE_W +: BYTE_W] <= data_i[k*BYTE_W +: BYTE_W];
  end
  if (OUT_REG) begin : g_oreg
    logic v1;
    logic [WIDTH-1:0] d1;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v1       <= 1'b0;
        d1       <= '0;
        rvalid_o <= 1'b0;
        data_o   <= '0;
      end else begin
        v1       <= acc_r;
        d1       <= acc_r ? rd_w : d1;
        rvalid_o <= v1;
        data_o   <= v1 ? d1 : data_o;
      end
    end
  end else begin : g_noreg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rvalid_o <= 1'b0;
        data_o   <= '0;
      end else begin
        rvalid_o <= acc_r;
        data_o   <= acc_r ? rd_w : data_o;
      end
    end
  end
endmodule

// File: tb/tb_sdp_ram_be.sv
// tb_sdp_ram_be: random and directed checks of two RAM variants against an array-based reference model.
module tb_sdp_ram_be;
  localparam int W  = 32;
  localparam int AW = 4;
  logic clk = 1'b0;
  logic rst_n, wen, ren, clr;
  logic [3:0] be;
  logic [AW-1:0] wa, ra;
  logic [W-1:0] din;
  logic [W-1:0] do0, do1;
  logic rv0, rv1, rdy0, rdy1;
  int vectors = 0;
  int miscompares = 0;
  int dep[2] = '{16, 12};
  int lat[2] = '{1, 2};
  bit rdw[2] = '{1'b0, 1'b1};
  logic [W-1:0] m[2][16];
  int cl[2];
  bit acc[2][4096];
  logic [W-1:0] wd[2][4096];
  logic [W-1:0] e[2];
  bit ev[2];
  int n = 0;
  always #5 clk = ~clk;
  sdp_ram_be #(.WIDTH(32), .DEPTH(16), .BYTE_W(8), .OUT_REG(0), .RDW_NEW(0), .CLEAR_ON_RESET(1)) u0 (
    .clk(clk), .rst_n(rst_n), .wen_i(wen), .be_i(be), .waddr_i(wa), .data_i(din),
    .ren_i(ren), .raddr_i(ra), .clear_i(clr), .data_o(do0), .rvalid_o(rv0), .ready_o(rdy0)
  );
  sdp_ram_be #(.WIDTH(32), .DEPTH(12), .BYTE_W(8), .OUT_REG(1), .RDW_NEW(1), .CLEAR_ON_RESET(1)) u1 (
    .clk(clk), .rst_n(rst_n), .wen_i(wen), .be_i(be), .waddr_i(wa), .data_i(din),
    .ren_i(ren), .raddr_i(ra), .clear_i(clr), .data_o(do1), .rvalid_o(rv1), .ready_o(rdy1)
  );
  task automatic chk(string tag, logic [W-1:0] got, logic [W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [W-1:0] merge(logic [W-1:0] o, logic [W-1:0] d, logic [3:0] b);
    logic [W-1:0] r;
    r = o;
    for (int k = 0; k < 4; k++) if (b[k]) r[k*8 +: 8] = d[k*8 +: 8];
    return r;
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      e[i] = '0;
      ev[i] = 1'b0;
      cl[i] = dep[i];
      acc[i][n % 4096] = 1'b0;
      if (n > 0) acc[i][(n - 1) % 4096] = 1'b0;
    end
  endtask
  task automatic model_edge();
    n++;
    for (int i = 0; i < 2; i++) begin
      bit a;
      logic [W-1:0] w;
      int k;
      a = 1'b0;
      w = '0;
      if (cl[i] > 0) begin
        m[i][dep[i] - cl[i]] = '0;
        cl[i]--;
      end else begin
        if (ren) begin
          a = 1'b1;
          w = (int'(ra) < dep[i]) ? m[i][ra] : '0;
          if (rdw[i] && wen && wa == ra && int'(wa) < dep[i]) w = merge(w, din, be);
        end
        if (wen && int'(wa) < dep[i]) m[i][wa] = merge(m[i][wa], din, be);
        if (clr) cl[i] = dep[i];
      end
      acc[i][n % 4096] = a;
      wd[i][n % 4096] = w;
      k = n - lat[i] + 1;
      ev[i] = k > 0 && acc[i][k % 4096];
      if (ev[i]) e[i] = wd[i][k % 4096];
    end
  endtask
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("u0 ready", W'(rdy0), W'(cl[0] == 0));
    chk("u1 ready", W'(rdy1), W'(cl[1] == 0));
    chk("u0 rvalid", W'(rv0), W'(ev[0]));
    chk("u1 rvalid", W'(rv1), W'(ev[1]));
    chk("u0 data", do0, e[0]);
    chk("u1 data", do1, e[1]);
  endtask
  task automatic reset_checks();
    chk("rst u0 data", do0, '0);
    chk("rst u1 data", do1, '0);
    chk("rst u0 rvalid", W'(rv0), '0);
    chk("rst u1 rvalid", W'(rv1), '0);
    chk("rst u0 ready", W'(rdy0), '0);
    chk("rst u1 ready", W'(rdy1), '0);
  endtask
  task automatic idle();
    wen = 1'b0;
    ren = 1'b0;
    clr = 1'b0;
  endtask
  task automatic read_all();
    idle();
    for (int a = 0; a < 16; a++) begin
      ren = 1'b1;
      ra = AW'(a);
      step();
    end
    idle();
    repeat (2) step();
  endtask
  task automatic wr(int a, logic [W-1:0] d, logic [3:0] b);
    wen = 1'b1;
    wa = AW'(a);
    din = d;
    be = b;
  endtask
  initial begin
    rst_n = 1'b0;
    idle();
    be = '0;
    wa = '0;
    ra = '0;
    din = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset_checks();
    rst_n = 1'b1;
    repeat (17) step();
    read_all();
    wr(3, 32'hAABBCCDD, 4'b1111);
    step();
    wr(3, 32'h11223344, 4'b0101);
    step();
    idle();
    ren = 1'b1;
    ra = 4'd3;
    step();
    idle();
    chk("lane merge u0", do0, 32'hAA22CC44);
    step();
    chk("lane merge u1", do1, 32'hAA22CC44);
    wr(5, 32'hFFFFFFFF, 4'b0011);
    ren = 1'b1;
    ra = 4'd5;
    step();
    idle();
    chk("rdw old u0", do0, 32'h00000000);
    step();
    chk("rdw new u1", do1, 32'h0000FFFF);
    for (int a = 0; a < 3; a++) begin
      ren = 1'b1;
      ra = AW'(a);
      step();
    end
    idle();
    repeat (2) step();
    wr(13, 32'hDEADBEEF, 4'b1111);
    step();
    idle();
    ren = 1'b1;
    ra = 4'd13;
    step();
    idle();
    repeat (2) step();
    repeat (800) begin
      wen = 1'($urandom_range(0, 1));
      ren = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 63) == 0);
      be = 4'($urandom);
      wa = AW'($urandom_range(0, 15));
      ra = AW'($urandom_range(0, 15));
      din = $urandom;
      step();
    end
    idle();
    repeat (20) step();
    for (int a = 0; a < 16; a++) begin
      wr(a, $urandom | 32'h1, 4'b1111);
      step();
    end
    idle();
    ren = 1'b1;
    ra = 4'd9;
    step();
    idle();
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (16) begin
      wr($urandom_range(0, 15), $urandom, 4'b1111);
      step();
    end
    read_all();
    wr(2, 32'h5A5A5A5A, 4'b1111);
    step();
    idle();
    ren = 1'b1;
    ra = 4'd2;
    step();
    idle();
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (7) step();
    rst_n = 1'b0;
    #1;
    reset_checks();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (17) step();
    read_all();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
